// File: rtl/la_des4_pkg.sv
// la_des4_pkg: shared word width and bit-order helper for the nibble deserializer
package la_des4_pkg;

    localparam int WORD_W = 4;

    // Map an LSB-first assembled word onto the configured output bit order.
    function automatic logic [WORD_W-1:0] order_word(input logic [WORD_W-1:0] w, input bit msb_first);
        return msb_first ? {w[0], w[1], w[2], w[3]} : w;
    endfunction

endpackage

// File: rtl/la_des4.sv
// la_des4: serial-to-nibble deserializer with holding register and start-of-word resync
module la_des4
    import la_des4_pkg::*;
#(
    parameter string PROP     = "DEFAULT",
    parameter bit    MSBFIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_data,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_err
);

    localparam logic [1:0] LAST = 2'd3;

    logic [1:0]        cnt_q, cnt_d;
    logic [2:0]        sr_q, sr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              accept, drain;

    // PROP only travels through to technology mapping; this empty block just references it.
    if (PROP == "") begin : g_prop_empty
    end

    // Only the 4th bit of a word stalls, and only when the held word cannot leave this cycle.
    assign in_ready  = ~reset & ~(cnt_q == LAST & valid_q & ~out_ready);
    assign accept    = in_valid & in_ready;
    assign drain     = valid_q & out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_err   = err_q;

    // Next state: new bits shift in from the top so that after three shifts sr_q[0] holds the first bit.
    always_comb begin
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        data_d  = data_q;
        valid_d = valid_q & ~drain;
        err_d   = 1'b0;
        if (accept & in_sof) begin
            sr_d  = {in_data, 2'b00};
            cnt_d = 2'd1;
            err_d = cnt_q != 2'd0;
        end else if (accept & (cnt_q == LAST)) begin
            data_d  = order_word({in_data, sr_q}, MSBFIRST);
            valid_d = 1'b1;
            cnt_d   = 2'd0;
        end else if (accept) begin
            sr_d  = {in_data, sr_q[2:1]};
            cnt_d = cnt_q + 2'd1;
        end
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            sr_q    <= 3'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_la_des4.sv
// tb_la_des4: randomized scoreboard bench for both bit orders of la_des4
module tb_la_des4;

    logic       clk = 1'b0, reset = 1'b1;
    logic       in_valid = 1'b0, in_data = 1'b0, in_sof = 1'b0, out_ready = 1'b0;
    logic       rdy0, rdy1, ov0, ov1, err0, err1;
    logic [3:0] d0, d1;

    int         vec = 0, bad = 0, words = 0;
    bit         exp_err = 1'b0;
    logic [3:0] sbq[$];
    bit         bits[$];

    always #5 clk = ~clk;

    la_des4 #(.PROP("DEFAULT"), .MSBFIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data), .in_sof(in_sof),
        .out_valid(ov0), .out_ready(out_ready), .out_data(d0), .out_err(err0));

    la_des4 #(.PROP("DEFAULT"), .MSBFIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data), .in_sof(in_sof),
        .out_valid(ov1), .out_ready(out_ready), .out_data(d1), .out_err(err1));

    function automatic logic [3:0] rev(input logic [3:0] w);
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", n, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from the spec's rules and records results.
    task automatic cyc(input bit v, input bit d, input bit s, input bit r, output bit acc);
        bit         rdy, err;
        logic [3:0] w;
        in_valid  = v;
        in_data   = d;
        in_sof    = s;
        out_ready = r;
        rdy = !(bits.size() == 3 && sbq.size() > 0 && !r);
        #1;
        chk("in_ready", rdy0, rdy);
        chk("in_ready_msb", rdy1, rdy);
        acc = v && rdy;
        @(posedge clk);
        #1;
        err = 1'b0;
        if (acc && s) begin
            err = bits.size() != 0;
            bits.delete();
            bits.push_back(d);
        end else if (acc) begin
            bits.push_back(d);
            if (bits.size() == 4) begin
                w = '0;
                foreach (bits[i]) w[i] = bits[i];
                sbq.push_back(w);
                bits.delete();
                words++;
            end
        end
        exp_err = err;
    endtask

    task automatic send(input bit d, input bit s, input bit r);
        bit acc;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, d, s, r, acc);
            if (acc) return;
        end
        chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic send_word(input logic [3:0] w, input bit r);
        for (int i = 0; i < 4; i++) send(w[i], 1'b0, r);
    endtask

    // Assert reset mid-cycle, check outputs clear at once, then release away from the edge.
    task automatic do_reset();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        reset    = 1'b1;
        sbq.delete();
        bits.delete();
        exp_err = 1'b0;
        #1;
        chk("rst_out_valid", ov0, 1'b0);
        chk("rst_out_data", d0, 4'h0);
        chk("rst_out_data_msb", d1, 4'h0);
        chk("rst_out_err", err0, 1'b0);
        chk("rst_in_ready", rdy0, 1'b0);
        chk("rst_in_ready_msb", rdy1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compares held/drained words and the error pulse against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", ov0, sbq.size() > 0);
            chk("out_valid_msb", ov1, sbq.size() > 0);
            chk("out_err", err0, exp_err);
            chk("out_err_msb", err1, exp_err);
            if (sbq.size() > 0) begin
                chk("word", d0, sbq[0]);
                chk("word_msb", d1, rev(sbq[0]));
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        bit acc;
        int cycles;
        @(posedge clk);
        #1;
        do_reset();
        // 1,0,1,1 -> 4'hD LSB-first, 4'hB MSB-first
        send(1'b1, 1'b0, 1'b1);
        send(1'b0, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        idle(3);
        // 4'h3 held while 4'hA assembles; 4th bit stalls until out_ready rises
        send_word(4'h3, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        repeat (3) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, acc);
            chk("stall_4th_bit", acc, 1'b0);
        end
        send(1'b1, 1'b0, 1'b1);
        idle(3);
        // resync after two bits: error pulse, then 4'h9
        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b1, 1'b1);
        send(1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        idle(3);
        // reset with a pending word and a partial word, then 0,1,1,0 -> 4'h6
        send_word(4'h5, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        do_reset();
        send_word(4'h6, 1'b1);
        idle(3);
        // random gaps, back-pressure and occasional resyncs
        words  = 0;
        cycles = 0;
        while (words < 1000 && cycles < 40000) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
                $urandom_range(0, 2) != 0, acc);
            cycles++;
        end
        chk("random_budget", words >= 1000, 1'b1);
        idle(4);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
